// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM state encoding and index types for the NTT stage sequencer.
package ntt_pkg;
    localparam int MAX_LOG_N_DEF = 8;
    localparam int MIN_LOG_N_DEF = 3;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} seq_state_t;
    typedef logic [MAX_LOG_N_DEF-1:0] addr_t;
    typedef logic [MAX_LOG_N_DEF-1:0] tw_t;
endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// ntt_stage_sequencer_if: issue-beat bus from the sequencer (master) to the butterfly datapath (slave).
interface ntt_stage_sequencer_if
    import ntt_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int MAX_LOG_N = MAX_LOG_N_DEF
);
    logic                         o_valid;
    logic                         i_ready;
    logic [LANES*MAX_LOG_N-1:0]   o_addr1;
    logic [LANES*MAX_LOG_N-1:0]   o_addr2;
    logic [LANES*MAX_LOG_N-1:0]   o_twiddle;
    logic [3:0]                   o_stage;
    logic                         o_new_stage;
    modport master (
        output o_valid, o_addr1, o_addr2, o_twiddle, o_stage, o_new_stage,
        input  i_ready
    );
    modport slave (
        input  o_valid, o_addr1, o_addr2, o_twiddle, o_stage, o_new_stage,
        output i_ready
    );
endinterface

// File: rtl/ntt_bfly_addr.sv
// ntt_bfly_addr: combinational butterfly address pair and twiddle index for butterfly bl of stage s.
module ntt_bfly_addr
    import ntt_pkg::*;
#(
    parameter int MAX_LOG_N = MAX_LOG_N_DEF
) (
    input  logic [MAX_LOG_N-1:0] i_bl,
    input  logic [3:0]           i_s,
    output logic [MAX_LOG_N-1:0] o_addr1,
    output logic [MAX_LOG_N-1:0] o_addr2,
    output logic [MAX_LOG_N-1:0] o_k
);
    logic [MAX_LOG_N-1:0] w_h, w_low;
    always_comb begin
        w_h     = MAX_LOG_N'(1) << i_s;
        w_low   = i_bl & (w_h - MAX_LOG_N'(1));
        o_addr1 = ((i_bl >> i_s) << (i_s + 4'd1)) | w_low;
        o_addr2 = o_addr1 + w_h;
        o_k     = w_low << (4'(MAX_LOG_N - 1) - i_s);
    end
endmodule

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: radix-2 DIT NTT issue sequencer with a PIPE_LAT drain gap between stages.
// Optional NTT_SEQ_INVERSE_EN adds i_inverse, which negates twiddle indices modulo MAX_N.
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int MAX_LOG_N = MAX_LOG_N_DEF,
    parameter int MIN_LOG_N = MIN_LOG_N_DEF,
    parameter int LANES     = 2,
    parameter int PIPE_LAT  = 6
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [3:0]            i_log_n,
    input  logic                  i_abort,
`ifdef NTT_SEQ_INVERSE_EN
    input  logic                  i_inverse,
`endif
    ntt_stage_sequencer_if.master io_bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    localparam int DW = $clog2(PIPE_LAT + 2);
    localparam int VW = LANES * MAX_LOG_N;

    seq_state_t           r_state, w_nstate;
    logic [3:0]           r_log_n, w_nlog_n, r_stage, w_nstage;
    logic [MAX_LOG_N-1:0] r_b, w_nb, w_half, w_b_inc;
    logic [DW-1:0]        r_drain, w_ndrain;
    logic                 w_err, w_iss;
    logic [VW-1:0]        w_a1, w_a2, w_tw;
    logic [VW-1:0]        r_addr1, r_addr2, r_twiddle;
    logic                 r_valid, r_new_stage, r_busy, r_done, r_err;

`ifdef NTT_SEQ_INVERSE_EN
    logic r_inverse, w_ninv;
    // Tracks the input while idle, so it holds the value seen on the accepted start cycle.
    assign w_ninv = (r_state == IDLE) ? i_inverse : r_inverse;
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) r_inverse <= 1'b0;
        else         r_inverse <= w_ninv;
    end
`endif

    // Lanes are fed the next-cycle butterfly index so the results land in registers aligned with the state.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [MAX_LOG_N-1:0] w_k;
        ntt_bfly_addr #(.MAX_LOG_N(MAX_LOG_N)) u_bfly (
            .i_bl    (w_nb + MAX_LOG_N'(l)),
            .i_s     (w_nstage),
            .o_addr1 (w_a1[l*MAX_LOG_N +: MAX_LOG_N]),
            .o_addr2 (w_a2[l*MAX_LOG_N +: MAX_LOG_N]),
            .o_k     (w_k)
        );
`ifdef NTT_SEQ_INVERSE_EN
        assign w_tw[l*MAX_LOG_N +: MAX_LOG_N] = w_ninv ? -w_k : w_k;
`else
        assign w_tw[l*MAX_LOG_N +: MAX_LOG_N] = w_k;
`endif
    end

    always_comb begin
        w_nstate = r_state;
        w_nlog_n = r_log_n;
        w_nstage = r_stage;
        w_nb     = r_b;
        w_ndrain = r_drain;
        w_err    = 1'b0;
        w_half   = MAX_LOG_N'(1) << (r_log_n - 4'd1);
        w_b_inc  = r_b + MAX_LOG_N'(LANES);
        case (r_state)
            IDLE: if (i_start) begin
                if (i_log_n >= 4'(MIN_LOG_N) && i_log_n <= 4'(MAX_LOG_N)) begin
                    w_nstate = ISSUE;
                    w_nlog_n = i_log_n;
                    w_nstage = '0;
                    w_nb     = '0;
                end else begin
                    w_err = 1'b1;
                end
            end
            ISSUE: if (io_bus.i_ready) begin
                w_nb = w_b_inc;
                if (w_b_inc == w_half) begin
                    w_nstate = DRAIN;
                    w_ndrain = DW'(PIPE_LAT);
                end
            end
            DRAIN: if (r_drain == '0) begin
                if (r_stage == r_log_n - 4'd1) begin
                    w_nstate = FINISH;
                end else begin
                    w_nstate = ISSUE;
                    w_nstage = r_stage + 4'd1;
                    w_nb     = '0;
                end
            end else begin
                w_ndrain = r_drain - DW'(1);
            end
            default: w_nstate = IDLE;
        endcase
        if (i_abort && r_state != IDLE) w_nstate = IDLE;
        w_iss = (w_nstate == ISSUE);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_log_n     <= '0;
            r_stage     <= '0;
            r_b         <= '0;
            r_drain     <= '0;
            r_valid     <= 1'b0;
            r_new_stage <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_twiddle   <= '0;
        end else begin
            r_state     <= w_nstate;
            r_log_n     <= w_nlog_n;
            r_stage     <= w_nstage;
            r_b         <= w_nb;
            r_drain     <= w_ndrain;
            r_valid     <= w_iss;
            r_new_stage <= w_iss && (w_nb == '0);
            r_busy      <= (w_nstate != IDLE);
            r_done      <= (w_nstate == FINISH);
            r_err       <= w_err;
            r_addr1     <= w_iss ? w_a1 : '0;
            r_addr2     <= w_iss ? w_a2 : '0;
            r_twiddle   <= w_iss ? w_tw : '0;
        end
    end

    assign io_bus.o_valid     = r_valid;
    assign io_bus.o_addr1     = r_addr1;
    assign io_bus.o_addr2     = r_addr2;
    assign io_bus.o_twiddle   = r_twiddle;
    assign io_bus.o_stage     = r_stage;
    assign io_bus.o_new_stage = r_new_stage;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_err              = r_err;
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// tb_ntt_stage_sequencer: self-checking bench; beats compared against a group/offset butterfly enumeration model.
module tb_ntt_stage_sequencer;
    import ntt_pkg::*;
    localparam int AW    = 8;
    localparam int LANES = 2;
    localparam int PL    = 2;
    localparam int MAX_N = 1 << AW;

    logic       clk = 1'b0;
    logic       i_reset, i_start, i_abort;
    logic [3:0] i_log_n;
    logic       o_busy, o_done, o_err;
`ifdef NTT_SEQ_INVERSE_EN
    logic       i_inverse;
`endif
    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] exp_q[$];

    ntt_stage_sequencer_if #(.LANES(LANES), .MAX_LOG_N(AW)) bus ();

    ntt_stage_sequencer #(.MAX_LOG_N(AW), .MIN_LOG_N(3), .LANES(LANES), .PIPE_LAT(PL)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_log_n (i_log_n),
        .i_abort (i_abort),
`ifdef NTT_SEQ_INVERSE_EN
        .i_inverse (i_inverse),
`endif
        .io_bus  (bus),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] snap();
        return 64'({bus.o_valid, bus.o_addr1, bus.o_addr2, bus.o_twiddle, bus.o_stage, bus.o_new_stage});
    endfunction

    // Butterfly j of stage s sits in group j/h at offset j%h; twiddle step is MAX_N/(2h).
    task automatic build(input int ln, input bit inv);
        int half, h, jj, top, k;
        logic [AW*LANES-1:0] a1, a2, tw;
        exp_q.delete();
        half = 1 << (ln - 1);
        for (int s = 0; s < ln; s++) begin
            h = 1 << s;
            for (int j = 0; j < half; j += LANES) begin
                for (int l = 0; l < LANES; l++) begin
                    jj = j + l;
                    top = (jj / h) * 2 * h + jj % h;
                    k = (jj % h) * (MAX_N / (2 * h));
                    if (inv) k = (MAX_N - k) % MAX_N;
                    a1[l*AW +: AW] = AW'(top);
                    a2[l*AW +: AW] = AW'(top + h);
                    tw[l*AW +: AW] = AW'(k);
                end
                exp_q.push_back(64'({1'b1, a1, a2, tw, 4'(s), j == 0}));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready tied high, 1: toggling, 2: random
    task automatic run(input int ln, input int mode, input bit inv);
        logic [63:0] s, e;
        logic pv;
        bit rdy, done_seen;
        int n, nacc, nns, beats;
        build(ln, inv);
        beats = ln * (1 << (ln - 1)) / LANES;
        n = 0; nacc = 0; nns = 0; done_seen = 0;
        i_start = 1'b1;
        i_log_n = 4'(ln);
`ifdef NTT_SEQ_INVERSE_EN
        i_inverse = inv;
`endif
        tick();
        i_start = 1'b0;
        chk("start_latency_valid", bus.o_valid, 1);
        while (!done_seen && n < 5000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            bus.i_ready = rdy;
            pv = bus.o_valid;
            s = snap();
            tick();
            n++;
            if (pv && rdy) begin
                nacc++;
                if (s[0]) nns++;
                if (exp_q.size() == 0) chk("extra_beat", s, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", s, e);
                end
            end else if (pv) begin
                chk("stall_hold", snap(), s);
            end
            if (o_done) begin
                done_seen = 1;
                chk("busy_at_done", o_busy, 1);
            end
        end
        bus.i_ready = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("beat_count", nacc, beats);
        chk("new_stage_beats", nns, ln);
        if (mode == 0) chk("done_cycle", n, beats + ln * (PL + 1));
        tick();
        chk("idle_after_done", {o_busy, o_done, bus.o_valid}, 0);
    endtask

    typedef struct {
        int ln;
        bit err;
        bit busy;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int n, pulses;
        bit found;
        tbl = '{'{2, 1, 0}, '{9, 1, 0}, '{0, 1, 0}, '{15, 1, 0}, '{3, 0, 1}, '{8, 0, 1}, '{5, 0, 1}};
        i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_log_n = '0; bus.i_ready = 1'b0;
`ifdef NTT_SEQ_INVERSE_EN
        i_inverse = 1'b0;
`endif
        #12;
        chk("reset_state", {snap(), o_busy, o_done, o_err}, 0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        tick();

        foreach (tbl[i]) begin
            i_start = 1'b1;
            i_log_n = 4'(tbl[i].ln);
            tick();
            i_start = 1'b0;
            chk($sformatf("size_%0d_err", tbl[i].ln), o_err, tbl[i].err);
            chk($sformatf("size_%0d_busy", tbl[i].ln), {o_busy, bus.o_valid}, {tbl[i].busy, tbl[i].busy});
            if (tbl[i].busy) i_abort = 1'b1;
            tick();
            i_abort = 1'b0;
            chk($sformatf("size_%0d_after", tbl[i].ln), {o_err, o_busy, bus.o_valid}, 0);
        end

        run(3, 0, 0);
        run(4, 1, 0);

        // Abort in the drain gap after stage 1, then a clean restart.
        i_start = 1'b1; i_log_n = 4'd8; bus.i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        found = 0; n = 0;
        while (!found && n < 2000) begin
            tick();
            n++;
            found = (bus.o_stage == 4'd1) && !bus.o_valid && o_busy;
        end
        chk("abort_reached_drain", found, 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_idle", {o_busy, bus.o_valid, o_done}, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_done || o_busy) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        bus.i_ready = 1'b0;
        run(3, 0, 0);

        // Asynchronous reset while beats are being issued.
        i_start = 1'b1; i_log_n = 4'd5; bus.i_ready = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        chk("pre_reset_valid", bus.o_valid, 1);
        i_reset = 1'b1;
        #1;
        chk("async_reset_outputs", {snap(), o_busy, o_done, o_err}, 0);
        #2;
        i_reset = 1'b0;
        bus.i_ready = 1'b0;
        tick();
        run(4, 2, 0);

`ifdef NTT_SEQ_INVERSE_EN
        run(3, 0, 1);
        run(int'($urandom_range(3, 8)), 2, 1);
`endif
        for (int i = 0; i < 3; i++) run(int'($urandom_range(3, 8)), 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
